instr_fetch: RTL and testbench

//  Instruction fetch stage; sits directly upstream of the decoder and feeds it 32-bit instrs.

---
 rtl/instr_fetch_if.sv | 31 +++
 rtl/instr_fetch.sv | 143 ++++++++++++++
 tb/tb_instr_fetch.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Bundle of fetch-stage bus signals: the instruction-memory request/response channel,
// the redirect input from execute, and the instruction handshake toward the decoder.
interface instr_fetch_if;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_ready;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc,
    output instr_valid, instr, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc,
    input  instr_valid, instr, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: in-order word requests, prefetch FIFO toward the decoder, redirect flush.
// Optional IF_MISALIGN_TRAP_EN adds fetch_misalign, trapping on misaligned redirect targets.
module instr_fetch #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  instr_fetch_if.master bus
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic          fetch_misalign
`endif
);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned DISC_W = 16;
  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);

  logic [63:0]       fetch_pc_q, fetch_pc_d;
  logic [63:0]       resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [DISC_W-1:0] discard_q, discard_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [31:0]       data_q [FIFO_DEPTH];
  logic [63:0]       pc_q   [FIFO_DEPTH];

  logic              trap_active;
  logic [CNT_W:0]    occupancy;
  logic [DISC_W-1:0] in_flight;
  logic [63:0]       redirect_target;
  logic              req_fire;
  logic              push;
  logic              pop;
  logic              resp_drop;

`ifdef IF_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  always_comb begin
    misalign_d = misalign_q;
    if (bus.redirect_valid) begin
      misalign_d = (bus.redirect_pc[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign trap_active    = misalign_q;
  assign fetch_misalign = misalign_q;
`else
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^bus.redirect_pc[1:0];
  assign trap_active    = 1'b0;
`endif

  // Discarded responses are excluded: the issue gate only reserves space for live words.
  assign occupancy       = {1'b0, count_q} + {1'b0, outstanding_q};
  assign in_flight       = discard_q + DISC_W'(outstanding_q);
  assign redirect_target = {bus.redirect_pc[63:2], 2'b00};

  assign bus.imem_req_valid = !rst && !bus.redirect_valid && !trap_active && (occupancy < DEPTH_LIM);
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.instr_valid    = !rst && !trap_active && (count_q != '0);
  assign bus.instr          = data_q[rd_ptr_q];
  assign bus.instr_pc       = pc_q[rd_ptr_q];

  assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
  assign pop       = bus.instr_valid && bus.instr_ready;
  assign resp_drop = bus.imem_resp_valid && (discard_q != '0);
  assign push      = bus.imem_resp_valid && (discard_q == '0) && !bus.redirect_valid;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    if (bus.redirect_valid) begin
      // Every word still owed by memory becomes a discard, less one arriving right now.
      fetch_pc_d    = redirect_target;
      resp_pc_d     = redirect_target;
      outstanding_d = '0;
      count_d       = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      discard_d     = (bus.imem_resp_valid && (in_flight != '0)) ? in_flight - DISC_W'(1) : in_flight;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 64'd4;
      end
      if (resp_drop) begin
        discard_d = discard_q - DISC_W'(1);
      end
      if (push) begin
        resp_pc_d = resp_pc_q + 64'd4;
        wr_ptr_d  = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(push);
      count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= bus.imem_resp_data;
      pc_q[wr_ptr_q]   <= resp_pc_q;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: cycle table for streaming/stall, directed
// redirect sequences, then randomized traffic against a stream-level reference model.
module tb_instr_fetch;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_if bus();

`ifdef IF_MISALIGN_TRAP_EN
  logic fetch_misalign;
`endif

  instr_fetch #(
    .RESET_PC  (64'h1000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus)
`ifdef IF_MISALIGN_TRAP_EN
    ,
    .fetch_misalign(fetch_misalign)
`endif
  );

  int checks = 0;
  int passed = 0;

  // Instruction memory: word content is a fixed function of the address.
  function automatic logic [31:0] memWord(input logic [63:0] a);
    return (a[31:0] * 32'd2654435761) ^ a[63:32] ^ 32'h5A5A_0000;
  endfunction

  typedef struct {
    logic [63:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [63:0] acc_q[$];
  int          cyc      = 0;
  int          last_due = 0;
  int          lat_min  = 1;
  int          lat_max  = 1;

  always @(posedge clk) begin : mem_accept
    int d;
    if (rst) begin
      mem_q.delete();
      acc_q.delete();
      last_due = 0;
    end else begin
      if (bus.imem_resp_valid && mem_q.size() > 0) void'(mem_q.pop_front());
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        d = cyc + $urandom_range(lat_max, lat_min);
        if (d < last_due) d = last_due;
        last_due = d;
        mem_q.push_back('{bus.imem_req_addr, d});
        acc_q.push_back(bus.imem_req_addr);
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = memWord(mem_q[0].addr);
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = $urandom;
    end
  end

  task automatic applyStimulus(input logic r, input logic req_rdy, input logic ins_rdy,
                               input logic rd, input logic [63:0] rpc);
    @(negedge clk);
    rst                = r;
    bus.imem_req_ready = req_rdy;
    bus.instr_ready    = ins_rdy;
    bus.redirect_valid = rd;
    bus.redirect_pc    = rpc;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic doReset(input logic ins_rdy);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b1, ins_rdy, 1'b0, 64'h0);
      checkOutput("reset_req_valid", bus.imem_req_valid, 0);
      checkOutput("reset_instr_valid", bus.instr_valid, 0);
    end
  endtask

  typedef struct {
    logic        ins_rdy;
    logic        exp_rv;
    logic [63:0] exp_addr;
    logic        exp_iv;
    logic [63:0] exp_pc;
  } vec_t;

  vec_t        tbl[17];
  logic        found;
  logic [63:0] got_pc;
  logic [31:0] got_data;
  int          bad;
  int          delivered;

  initial begin
    rst                 = 1'b1;
    bus.imem_req_ready  = 1'b0;
    bus.instr_ready     = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 64'h0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;

    // Streaming with 1-cycle memory, then a 4-cycle decoder stall and release.
    tbl[0]  = '{1'b1, 1'b1, 64'h1000, 1'b0, 64'h0};
    tbl[1]  = '{1'b1, 1'b1, 64'h1004, 1'b0, 64'h0};
    tbl[2]  = '{1'b1, 1'b1, 64'h1008, 1'b1, 64'h1000};
    tbl[3]  = '{1'b1, 1'b1, 64'h100c, 1'b1, 64'h1004};
    tbl[4]  = '{1'b1, 1'b1, 64'h1010, 1'b1, 64'h1008};
    tbl[5]  = '{1'b1, 1'b1, 64'h1014, 1'b1, 64'h100c};
    tbl[6]  = '{1'b1, 1'b1, 64'h1018, 1'b1, 64'h1010};
    tbl[7]  = '{1'b1, 1'b1, 64'h101c, 1'b1, 64'h1014};
    tbl[8]  = '{1'b0, 1'b1, 64'h1020, 1'b1, 64'h1018};
    tbl[9]  = '{1'b0, 1'b1, 64'h1024, 1'b1, 64'h1018};
    tbl[10] = '{1'b0, 1'b0, 64'h0,    1'b1, 64'h1018};
    tbl[11] = '{1'b0, 1'b0, 64'h0,    1'b1, 64'h1018};
    tbl[12] = '{1'b1, 1'b0, 64'h0,    1'b1, 64'h1018};
    tbl[13] = '{1'b1, 1'b1, 64'h1028, 1'b1, 64'h101c};
    tbl[14] = '{1'b1, 1'b1, 64'h102c, 1'b1, 64'h1020};
    tbl[15] = '{1'b1, 1'b1, 64'h1030, 1'b1, 64'h1024};
    tbl[16] = '{1'b1, 1'b1, 64'h1034, 1'b1, 64'h1028};

    lat_min = 1; lat_max = 1;
    doReset(1'b1);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b0, 1'b1, tbl[i].ins_rdy, 1'b0, 64'h0);
      checkOutput($sformatf("t1_req_valid_%0d", i), bus.imem_req_valid, tbl[i].exp_rv);
      if (tbl[i].exp_rv) checkOutput($sformatf("t1_req_addr_%0d", i), bus.imem_req_addr, tbl[i].exp_addr);
      checkOutput($sformatf("t1_instr_valid_%0d", i), bus.instr_valid, tbl[i].exp_iv);
      if (tbl[i].exp_iv) begin
        checkOutput($sformatf("t1_instr_pc_%0d", i), bus.instr_pc, tbl[i].exp_pc);
        checkOutput($sformatf("t1_instr_%0d", i), bus.instr, memWord(tbl[i].exp_pc));
      end
    end

    // Decoder stalled from reset: issue stops at FIFO_DEPTH, head holds.
    doReset(1'b0);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
      if (k >= 2 && !(bus.instr_valid && bus.instr_pc == 64'h1000 && bus.instr == memWord(64'h1000))) bad++;
    end
    checkOutput("t2_head_stable", bad, 0);
    checkOutput("t2_req_count", acc_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
      checkOutput($sformatf("t2_pop_valid_%0d", k), bus.instr_valid, 1);
      checkOutput($sformatf("t2_pop_pc_%0d", k), bus.instr_pc, 64'h1000 + 64'(4 * k));
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("t2_resume_addr", acc_q.size() > 4 ? acc_q[4] : 64'hx, 64'h1010);

    // Memory back-pressure: request held with a stable address, no duplicates.
    doReset(1'b1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
      checkOutput($sformatf("t3_hold_valid_%0d", k), bus.imem_req_valid, 1);
      checkOutput($sformatf("t3_hold_addr_%0d", k), bus.imem_req_addr, 64'h1000);
    end
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("t3_first_accept", acc_q.size() > 1 ? acc_q[0] : 64'hx, 64'h1000);
    checkOutput("t3_second_accept", acc_q.size() > 1 ? acc_q[1] : 64'hx, 64'h1004);

    // Redirect with two buffered words and two still owed by a 3-cycle memory.
    lat_min = 3; lat_max = 3;
    doReset(1'b0);
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 64'h2000);
    checkOutput("t4_redirect_req_valid", bus.imem_req_valid, 0);
    checkOutput("t4_pre_head_pc", bus.instr_pc, 64'h1000);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("t4_flushed", bus.instr_valid, 0);
    checkOutput("t4_new_addr", bus.imem_req_addr, 64'h2000);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
      if (bus.instr_valid) begin
        found = 1'b1; got_pc = bus.instr_pc; got_data = bus.instr;
      end
    end
    checkOutput("t4_delivered", found, 1);
    checkOutput("t4_first_pc", got_pc, 64'h2000);
    checkOutput("t4_first_data", got_data, memWord(64'h2000));

    // Redirect coinciding with a response and a pop.
    lat_min = 1; lat_max = 1;
    doReset(1'b1);
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 64'h3000);
    checkOutput("t5_pop_valid", bus.instr_valid, 1);
    checkOutput("t5_pop_pc", bus.instr_pc, 64'h100c);
    bad = 0; delivered = 0;
    for (int k = 0; k < 15; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
      if (bus.instr_valid) begin
        if (bus.instr_pc != 64'h3000 + 64'(4 * delivered)) bad++;
        delivered++;
      end
    end
    checkOutput("t5_no_stale_pc", bad, 0);
    checkOutput("t5_new_stream_flows", delivered >= 10, 1);

    // Misaligned redirect target.
    doReset(1'b1);
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 64'h2002);
`ifdef IF_MISALIGN_TRAP_EN
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("t6_trap_set", fetch_misalign, 1);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
      if (bus.imem_req_valid || bus.instr_valid || !fetch_misalign) bad++;
    end
    checkOutput("t6_trap_quiet", bad, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 64'h2000);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("t6_trap_cleared", fetch_misalign, 0);
    checkOutput("t6_resume_addr", bus.imem_req_addr, 64'h2000);
`else
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("t6_req_valid", bus.imem_req_valid, 1);
    checkOutput("t6_aligned_addr", bus.imem_req_addr, 64'h2000);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
      if (bus.instr_valid) begin
        found = 1'b1; got_pc = bus.instr_pc;
      end
    end
    checkOutput("t6_delivered", found, 1);
    checkOutput("t6_first_pc", got_pc, 64'h2000);
`endif

    // Randomized traffic: model tracks the expected fetch/delivery streams only.
    lat_min = 1; lat_max = 4;
    doReset(1'b1);
    begin
      logic [63:0] exp_pc, exp_req, tgt, prev_pc, prev_addr;
      logic        rq, ir, rd, prev_hold, prev_req_pend;
      int          live, pops;
      exp_pc = 64'h1000; exp_req = 64'h1000; live = 0; pops = 0;
      prev_hold = 1'b0; prev_req_pend = 1'b0; prev_pc = '0; prev_addr = '0;
      for (int c = 0; c < 1500; c++) begin
        rq  = ($urandom_range(0, 3) != 0);
        ir  = ($urandom_range(0, 3) != 0);
        rd  = ($urandom_range(0, 24) == 0);
        tgt = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0
                                          : ({$urandom, $urandom} & ~64'h3);
        applyStimulus(1'b0, rq, ir, rd, tgt);
        if (prev_hold) begin
          checkOutput("rnd_head_hold_valid", bus.instr_valid, 1);
          checkOutput("rnd_head_hold_pc", bus.instr_pc, prev_pc);
        end
        if (rd) checkOutput("rnd_redirect_retracts", bus.imem_req_valid, 0);
        else if (prev_req_pend) begin
          checkOutput("rnd_req_hold_valid", bus.imem_req_valid, 1);
          checkOutput("rnd_req_hold_addr", bus.imem_req_addr, prev_addr);
        end
        if (bus.imem_req_valid && rq) begin
          checkOutput("rnd_req_addr", bus.imem_req_addr, exp_req);
          checkOutput("rnd_depth_cap", live < 4, 1);
          exp_req = exp_req + 64'd4;
          live++;
        end
        if (bus.instr_valid && ir) begin
          checkOutput("rnd_pop_pc", bus.instr_pc, exp_pc);
          checkOutput("rnd_pop_data", bus.instr, memWord(exp_pc));
          exp_pc = exp_pc + 64'd4;
          live--;
          pops++;
        end
        prev_hold     = bus.instr_valid && !ir && !rd;
        prev_pc       = bus.instr_pc;
        prev_req_pend = bus.imem_req_valid && !rq && !rd;
        prev_addr     = bus.imem_req_addr;
        if (rd) begin
          exp_pc = tgt; exp_req = tgt; live = 0;
        end
      end
      checkOutput("rnd_liveness", pops > 200, 1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
